// File: rtl/ex_div_unit.sv
// ---------------------------------------------------------------------------
// ex_div_unit
//   Multi-cycle restoring divider used by the EX stage for DIV / DIVU.
//   The EX stage raises start and holds it until ready is seen. While busy
//   is high the EX stage stalls the pipeline. annul throws away whatever the
//   unit is doing (a branch or delay-slot flush).
//
// Ports
//   clock       : single clock, all state changes on its rising edge
//   reset       : synchronous, active-high
//   signed_div  : 1 = DIV (two's complement), 0 = DIVU
//   opdata1     : dividend
//   opdata2     : divisor
//   start       : divide request, held high by EX until ready
//   annul       : abort the current or pending operation
//   result      : {remainder, quotient}; valid only while ready = 1
//   ready       : result valid (held until start drops)
//   busy        : high in BY_ZERO and RUN
//
// Handshake: a request is accepted on an edge where the unit is IDLE,
// start = 1 and annul = 0. ready then rises and stays high, with result
// stable, until an edge sees start = 0; that edge returns the unit to IDLE
// and clears ready/result. annul on any edge outside IDLE wins over
// everything except reset.
// ---------------------------------------------------------------------------
module ex_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      signed_div,
  input  logic [DATA_WIDTH-1:0]     opdata1,
  input  logic [DATA_WIDTH-1:0]     opdata2,
  input  logic                      start,
  input  logic                      annul,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      ready,
  output logic                      busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] STEPS = CW'(W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    RUN     = 2'd2,
    END     = 2'd3
  } div_state_e;

  div_state_e state, state_n;

  // work holds {partial remainder, next dividend bit, quotient bits}. The
  // remainder lives in work[2W:W+1] and the quotient collects in work[W-1:0].
  logic [2*W:0]   work, work_n;
  logic [CW-1:0]  counter, counter_n;
  logic [W-1:0]   div_mag, div_mag_n;
  logic           neg_a_q, neg_a_n;
  logic           neg_d_q, neg_d_n;
  logic [2*W-1:0] result_n;
  logic           ready_n;
  logic           busy_n;

  // Combinational helpers
  logic           in_neg_a;
  logic           in_neg_d;
  logic [W-1:0]   in_mag_a;
  logic [W-1:0]   in_mag_d;
  logic [W:0]     trial;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  // Operand magnitudes: only signed requests with a set sign bit are negated.
  assign in_neg_a = signed_div & opdata1[W-1];
  assign in_neg_d = signed_div & opdata2[W-1];
  assign in_mag_a = in_neg_a ? (~opdata1 + W'(1)) : opdata1;
  assign in_mag_d = in_neg_d ? (~opdata2 + W'(1)) : opdata2;

  // One restoring step: try to subtract the divisor from {remainder, next bit}.
  assign trial = work[2*W:W] - {1'b0, div_mag};

  // Sign fix-up: quotient negative when signs differ, remainder follows the
  // dividend. Both flags are zero for unsigned requests.
  assign quo_fix = (neg_a_q ^ neg_d_q) ? (~work[W-1:0] + W'(1)) : work[W-1:0];
  assign rem_fix = neg_a_q ? (~work[2*W:W+1] + W'(1)) : work[2*W:W+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      work    <= '0;
      counter <= '0;
      div_mag <= '0;
      neg_a_q <= 1'b0;
      neg_d_q <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      work    <= work_n;
      counter <= counter_n;
      div_mag <= div_mag_n;
      neg_a_q <= neg_a_n;
      neg_d_q <= neg_d_n;
      result  <= result_n;
      ready   <= ready_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    work_n    = work;
    counter_n = counter;
    div_mag_n = div_mag;
    neg_a_n   = neg_a_q;
    neg_d_n   = neg_d_q;
    result_n  = result;
    ready_n   = ready;
    busy_n    = 1'b0;

    case (state)
      IDLE: begin
        if (start && !annul) begin
          neg_a_n   = in_neg_a;
          neg_d_n   = in_neg_d;
          div_mag_n = in_mag_d;
          counter_n = '0;
          if (opdata2 == '0) begin
            state_n = BY_ZERO;
          end else begin
            state_n = RUN;
            work_n  = {{W{1'b0}}, in_mag_a, 1'b0};
          end
        end
      end

      BY_ZERO: begin
        state_n  = END;
        result_n = '0;
        ready_n  = 1'b1;
      end

      RUN: begin
        if (counter < STEPS) begin
          if (trial[W]) begin
            work_n = {work[2*W-1:0], 1'b0};
          end else begin
            work_n = {trial[W-1:0], work[W-1:0], 1'b1};
          end
          counter_n = counter + CW'(1);
        end else begin
          result_n = {rem_fix, quo_fix};
          ready_n  = 1'b1;
          state_n  = END;
        end
      end

      END: begin
        if (!start) begin
          state_n  = IDLE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end

      default: begin
        state_n  = IDLE;
        ready_n  = 1'b0;
        result_n = '0;
      end
    endcase

    // Flush: discard any in-flight or finished result.
    if (annul && state != IDLE) begin
      state_n  = IDLE;
      ready_n  = 1'b0;
      result_n = '0;
    end

    busy_n = (state_n == BY_ZERO) || (state_n == RUN);
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_div_unit
//   Self-checking bench for ex_div_unit: directed cases plus randomized
//   DIV / DIVU requests compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_div_unit;

  logic        clock;
  logic        reset;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  ex_div_unit #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain integer division. SV '/' and '%' truncate toward
  // zero and the remainder takes the dividend sign, as a MIPS DIV does.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver: issue one request, hold start until ready, check latency, busy
  // time, result, END hold behaviour and the drop back to idle.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, input string tag);
    int n;
    int busy_cnt;
    int exp_lat;
    int exp_busy;
    bit got;
    logic [63:0] exp;
    exp_q.push_back(model(sgn, a, b));
    exp_lat  = (b == 32'd0) ? 2 : 34;
    exp_busy = (b == 32'd0) ? 1 : 33;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    n = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      tick();
      n++;
      if (ready) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (toggle) begin
          signed_div = 1'($urandom_range(0, 1));
          opdata1    = $urandom();
          opdata2    = $urandom();
        end
      end
    end
    exp = exp_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_latency"}, 64'(n), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
      check({tag, "_result"}, result, exp);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      tick();
      check({tag, "_hold_ready"}, 64'(ready), 64'd1);
      check({tag, "_hold_result"}, result, exp);
    end
    start = 1'b0;
    tick();
    check({tag, "_drop_ready"}, 64'(ready), 64'd0);
    check({tag, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    reset      = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    tick();
    tick();
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
    check("model_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    do_div(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, "div_m7_2");
    do_div(1'b1, 32'h7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
    do_div(1'b0, 32'h1234_5678, 32'h0, 1'b0, "divu_by_zero");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_no_negate");

    // Annul in RUN at counter == 10 (sampled on edge 12 after acceptance)
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (11) tick();
    check("annul_run_busy_before", 64'(busy), 64'd1);
    annul = 1'b1;
    tick();
    check("annul_run_ready", 64'(ready), 64'd0);
    check("annul_run_busy", 64'(busy), 64'd0);
    check("annul_run_result", result, 64'd0);
    // start together with annul in IDLE is ignored
    tick();
    check("annul_start_ignored", 64'(busy), 64'd0);
    annul = 1'b0;
    start = 1'b0;
    do_div(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, "divu_after_annul");

    // Annul in BY_ZERO
    opdata2 = 32'd0;
    start   = 1'b1;
    tick();
    annul = 1'b1;
    tick();
    check("annul_byzero_ready", 64'(ready), 64'd0);
    check("annul_byzero_busy", 64'(busy), 64'd0);
    annul = 1'b0;
    start = 1'b0;
    tick();

    // Annul in END while start still high
    opdata1 = 32'd9;
    opdata2 = 32'd0;
    start   = 1'b1;
    tick();
    tick();
    check("end_reached_ready", 64'(ready), 64'd1);
    annul = 1'b1;
    tick();
    check("annul_end_ready", 64'(ready), 64'd0);
    annul = 1'b0;
    start = 1'b0;
    tick();

    // Reset mid-RUN
    signed_div = 1'b1;
    opdata1    = 32'h7654_3210;
    opdata2    = 32'd5;
    start      = 1'b1;
    repeat (20) tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("reset_run_ready", 64'(ready), 64'd0);
    check("reset_run_busy", 64'(busy), 64'd0);
    check("reset_run_result", result, 64'd0);
    reset = 1'b0;
    tick();
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_after_reset");

    // Operands toggled during RUN
    do_div(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, "toggle_div");
    do_div(1'b0, 32'hCAFE_F00D, 32'h0000_0007, 1'b1, "toggle_divu");

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'h8000_0000;
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_div(rs, ra, rb, 1'($urandom_range(0, 1)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
